// File: rtl/irq_sequencer_pkg.sv
// irq_sequencer_pkg: shared constants and state encoding for the interrupt sequencer
//   IRQ_COUNT    default number of interrupt lines driven into the core
//   PULSE_W      width of each per-line pulse stretch counter
//   seq_state_t  playback state encoding: IDLE, RUN, DONE
package irq_sequencer_pkg;
  localparam int IRQ_COUNT = 32;
  localparam int PULSE_W = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;
endpackage

// File: rtl/irq_pulse_stretcher.sv
// irq_pulse_stretcher: holds one interrupt line high for PULSE cycles after a load
//   clk    system clock
//   reset  asynchronous, active-low
//   load   reload the counter to PULSE (a re-fire restarts the pulse, it does not extend it)
//   clear  force the counter to zero; wins over load
//   line   registered output, high while the counter is non-zero
module irq_pulse_stretcher
  import irq_sequencer_pkg::*;
#(
  parameter int PULSE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic line
);
  logic [PULSE_W-1:0] cnt, cnt_next;
  always_comb cnt_next = clear ? '0 : load ? PULSE_W'(PULSE) : (cnt != '0) ? cnt - 1'b1 : '0;
  // line follows the counter's next value so it rises the cycle after the load
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt  <= '0;
      line <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      line <= cnt_next != '0;
    end
endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: plays a table of (clock-time, irq-line) entries onto the core's interrupt inputs
//   clk        system clock
//   reset      asynchronous, active-low
//   wr_en      table write strobe; wr_addr/wr_time/wr_sig give index, fire time and line
//   cfg_first  first entry played, sampled on start
//   cfg_last   one past the last entry played, sampled on start
//   start      begin playback from IDLE or DONE
//   abort      stop playback and clear all pulses; wins over start
//   irqs       registered interrupt lines
//   clk_count  clocks elapsed since start, saturating
//   busy       high while playing
//   done       high once the range has been consumed
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int IRQS  = IRQ_COUNT,
  parameter int SW    = 5,
  parameter int TW    = 32,
  parameter int PULSE = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [TW-1:0]   wr_time,
  input  logic [SW-1:0]   wr_sig,
  input  logic [AW-1:0]   cfg_first,
  input  logic [AW-1:0]   cfg_last,
  input  logic            start,
  input  logic            abort,
  output logic [IRQS-1:0] irqs,
  output logic [TW-1:0]   clk_count,
  output logic            busy,
  output logic            done
);
  logic [TW-1:0] time_mem [DEPTH];
  logic [SW-1:0] sig_mem [DEPTH];
  seq_state_t state, state_n;
  logic [AW-1:0] ptr, ptr_n, last, last_n;
  logic [TW-1:0] cnt_n, rd_time;
  logic [SW-1:0] rd_sig;
  logic fire;
  always_ff @(posedge clk)
    if (wr_en && 32'(wr_addr) < DEPTH) begin
      time_mem[wr_addr] <= wr_time;
      sig_mem[wr_addr]  <= wr_sig;
    end
  assign rd_time = time_mem[ptr];
  assign rd_sig  = sig_mem[ptr];
  // catch-up compare: a backlog of due entries drains one per cycle
  assign fire = state == RUN && ptr != last && rd_time <= clk_count;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    last_n  = last;
    cnt_n   = clk_count;
    if (abort) begin
      state_n = IDLE;
      ptr_n   = '0;
    end else if (state != RUN && start) begin
      ptr_n   = cfg_first;
      last_n  = cfg_last;
      cnt_n   = '0;
      state_n = cfg_first >= cfg_last ? DONE : RUN;
    end else if (state == RUN) begin
      cnt_n   = &clk_count ? clk_count : clk_count + 1'b1;
      ptr_n   = fire ? ptr + 1'b1 : ptr;
      state_n = ptr == last ? DONE : RUN;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      last      <= '0;
      clk_count <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      last      <= last_n;
      clk_count <= cnt_n;
    end
  // entries whose sig is outside 0..IRQS-1 match no line: consumed silently
  for (genvar i = 0; i < IRQS; i++) begin : g_line
    irq_pulse_stretcher #(.PULSE(PULSE)) u_str (
      .clk  (clk),
      .reset(reset),
      .load (fire && rd_sig == SW'(i)),
      .clear(abort),
      .line (irqs[i])
    );
  end
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed scoreboard bench for irq_sequencer
module tb_irq_sequencer;
  localparam int SW = 6;
  logic clk = 0, reset = 0, wr_en = 0, start = 0, abort = 0;
  logic [9:0] wr_addr = '0, cfg_first = '0, cfg_last = '0;
  logic [31:0] wr_time = '0;
  logic [SW-1:0] wr_sig = '0;
  logic [31:0] irqs, clk_count;
  logic busy, done;
  int errors = 0, checks = 0;
  typedef struct {
    string       tag;
    logic [31:0] irqs;
    logic [31:0] cnt;
    logic        busy;
    logic        done;
    bit          chk_cnt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  irq_sequencer #(.SW(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_time  (wr_time),
    .wr_sig   (wr_sig),
    .cfg_first(cfg_first),
    .cfg_last (cfg_last),
    .start    (start),
    .abort    (abort),
    .irqs     (irqs),
    .clk_count(clk_count),
    .busy     (busy),
    .done     (done)
  );

  task automatic push(string tag, logic [31:0] i, logic [31:0] c, logic b, logic d, bit cc);
    exp_t e;
    e.tag = tag; e.irqs = i; e.cnt = c; e.busy = b; e.done = d; e.chk_cnt = cc;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty got none want entry");
      return;
    end
    e = sb.pop_front();
    assert (irqs === e.irqs) else begin
      errors++;
      $error("FAIL %s irqs got %h want %h", e.tag, irqs, e.irqs);
    end
    assert (busy === e.busy && done === e.done) else begin
      errors++;
      $error("FAIL %s busy/done got %b%b want %b%b", e.tag, busy, done, e.busy, e.done);
    end
    if (e.chk_cnt)
      assert (clk_count === e.cnt) else begin
        errors++;
        $error("FAIL %s clk_count got %0d want %0d", e.tag, clk_count, e.cnt);
      end
  endtask

  task automatic wr(int a, int t, int s);
    wr_en = 1; wr_addr = 10'(a); wr_time = 32'(t); wr_sig = SW'(s);
    @(posedge clk); @(negedge clk);
    wr_en = 0;
  endtask

  task automatic play(int first, int last, int n, int restart_k, int abort_k);
    cfg_first = 10'(first); cfg_last = 10'(last); start = 1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); @(negedge clk);
      start = 0;
      compare();
      start = (k == restart_k) || (k == abort_k);
      abort = (k == abort_k);
    end
    start = 0; abort = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    push("reset", '0, '0, 0, 0, 1);
    compare();
    reset = 1;
    @(negedge clk);
    // single entry: fires at count 5, pulse visible at counts 6..7
    wr(0, 5, 3);
    for (int k = 0; k < 10; k++)
      push($sformatf("t1_c%0d", k), (k == 6 || k == 7) ? 32'h8 : 32'h0,
           32'(k <= 7 ? k : 7), k <= 6, k >= 7, 1);
    play(0, 1, 10, -1, -1);
    // equal times drain on consecutive cycles; line 1 reloads; start in RUN ignored
    wr(0, 4, 1); wr(1, 4, 2); wr(2, 4, 1);
    for (int k = 0; k < 11; k++)
      push($sformatf("t2_c%0d", k),
           {29'b0, (k == 6 || k == 7), (k >= 5 && k <= 8), 1'b0},
           32'(k <= 8 ? k : 8), k <= 7, k >= 8, 1);
    play(0, 3, 11, 2, -1);
    // out-of-range line index: consumed with no pulse
    wr(0, 3, 40);
    for (int k = 0; k < 7; k++)
      push($sformatf("t3_c%0d", k), '0, 32'(k <= 5 ? k : 5), k <= 4, k >= 5, 1);
    play(0, 1, 7, -1, -1);
    // async reset mid-pulse takes effect without a clock edge
    wr(0, 5, 3);
    for (int k = 0; k < 7; k++)
      push($sformatf("t4_c%0d", k), k == 6 ? 32'h8 : 32'h0, 32'(k), 1, 0, 1);
    play(0, 1, 7, -1, -1);
    reset = 0;
    #1;
    push("t4_async", '0, '0, 0, 0, 1);
    compare();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    // abort with start at count 10: entry due at 12 never fires
    wr(0, 12, 0);
    for (int k = 0; k < 22; k++)
      push($sformatf("t5_c%0d", k), '0, 32'(k), k <= 10, 0, k <= 10);
    play(0, 1, 22, -1, 10);
    // empty range goes straight to DONE
    for (int k = 0; k < 3; k++)
      push($sformatf("t6_c%0d", k), '0, '0, 0, 1, 1);
    play(2, 2, 3, -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
